// File: rtl/new_pe_unit_if.sv
// new_pe_unit data bus: weights, ifmap chain, and partial sums.
// Master drives the PE inputs; slave is the PE.
interface new_pe_unit_if;
  logic        en;
  logic [11:0] Filtr_in;
  logic [7:0]  Ifmap_shift_in;
  logic [13:0] Psum_in;
  logic [7:0]  Ifmap_shift_out;
  logic [13:0] Psum_out;

  modport master (
    output en, Filtr_in, Ifmap_shift_in, Psum_in,
    input  Ifmap_shift_out, Psum_out
  );

  modport slave (
    input  en, Filtr_in, Ifmap_shift_in, Psum_in,
    output Ifmap_shift_out, Psum_out
  );
endinterface

// File: rtl/new_pe_unit.sv
// 3-tap 1-D convolution PE: shifts ifmap, MACs with weights, adds upstream psum.
// Define NEW_PE_UNIT_PSUM_SAT_EN to saturate Psum_out instead of wrapping.
module new_pe_unit (
  input logic           clk,
  input logic           rst,
  new_pe_unit_if.slave  pe
);

  logic [7:0]  x0, x1, x2;
  logic [3:0]  w0, w1, w2;
  logic [11:0] p0, p1, p2;
  logic [13:0] tap_sum;
  logic [13:0] psum_nxt;
  logic [13:0] psum_q;

  assign w0 = pe.Filtr_in[3:0];
  assign w1 = pe.Filtr_in[7:4];
  assign w2 = pe.Filtr_in[11:8];

  // Products use the taps as they will be after this edge's shift.
  assign p0 = 12'(w0) * 12'(pe.Ifmap_shift_in);
  assign p1 = 12'(w1) * 12'(x0);
  assign p2 = 12'(w2) * 12'(x1);

  assign tap_sum = 14'(p0) + 14'(p1) + 14'(p2);

`ifdef NEW_PE_UNIT_PSUM_SAT_EN
  logic [14:0] full_sum;

  assign full_sum = 15'(pe.Psum_in) + 15'(tap_sum);

  always_comb begin
    psum_nxt = full_sum[13:0];
    if (full_sum[14])
      psum_nxt = 14'h3FFF;
  end
`else
  // Dropping the 15th bit is the modulo-2^14 wrap.
  always_comb begin
    psum_nxt = pe.Psum_in + tap_sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      x0     <= '0;
      x1     <= '0;
      x2     <= '0;
      psum_q <= '0;
    end else if (pe.en) begin
      x0     <= pe.Ifmap_shift_in;
      x1     <= x0;
      x2     <= x1;
      psum_q <= psum_nxt;
    end
  end

  assign pe.Ifmap_shift_out = x2;
  assign pe.Psum_out        = psum_q;

endmodule

// File: tb/tb_new_pe_unit.sv
// Directed self-checking bench for new_pe_unit with a result scoreboard.
// Build with +define+NEW_PE_UNIT_PSUM_SAT_EN to check the saturating variant.
module tb_new_pe_unit;

  typedef struct {
    string       tag;
    logic [13:0] ps;
    logic [7:0]  so;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int passed = 0;
  int total  = 0;

  exp_t sb[$];

  new_pe_unit_if bus ();

  new_pe_unit dut (
    .clk (clk),
    .rst (rst),
    .pe  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(string tag, string what,
                     logic [13:0] obs, logic [13:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s.%s: got %0d, expected %0d",
               tag, what, obs, exp);
      $error("check %s.%s", tag, what);
    end
  endtask

  // Drive one cycle; when chk is set, queue the expected outputs
  // and compare them after the edge.
  task automatic apply(input logic        r,
                       input logic        e,
                       input logic [11:0] f,
                       input logic [7:0]  x,
                       input logic [13:0] p,
                       input bit          chk,
                       input logic [13:0] exp_ps,
                       input logic [7:0]  exp_so,
                       input string       tag);
    exp_t item;
    rst                = r;
    bus.en             = e;
    bus.Filtr_in       = f;
    bus.Ifmap_shift_in = x;
    bus.Psum_in        = p;
    if (chk) begin
      item.tag = tag;
      item.ps  = exp_ps;
      item.so  = exp_so;
      sb.push_back(item);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      item = sb.pop_front();
      cmp(item.tag, "psum", bus.Psum_out, item.ps);
      cmp(item.tag, "shift", 14'(bus.Ifmap_shift_out), 14'(item.so));
    end
  endtask

  function automatic logic [11:0] rf();
    return 12'($urandom);
  endfunction

  function automatic logic [7:0] rx();
    return 8'($urandom);
  endfunction

  function automatic logic [13:0] rp();
    return 14'($urandom);
  endfunction

  localparam logic [11:0] W431 = 12'h431;
  localparam logic [11:0] W111 = 12'h111;

`ifdef NEW_PE_UNIT_PSUM_SAT_EN
  localparam logic [13:0] OVF_EXP = 14'd16383;
`else
  localparam logic [13:0] OVF_EXP = 14'd11474;
`endif

  initial begin
    rst                = 1'b1;
    bus.en             = 1'b0;
    bus.Filtr_in       = '0;
    bus.Ifmap_shift_in = '0;
    bus.Psum_in        = '0;

    // Reset with random inputs, en high to show reset wins.
    apply(1, 1, rf(), rx(), rp(), 1, 0, 0, "rst0");
    apply(1, 1, rf(), rx(), rp(), 1, 0, 0, "rst1");
    apply(0, 0, rf(), rx(), rp(), 1, 0, 0, "rst_hold0");
    apply(0, 0, rf(), rx(), rp(), 1, 0, 0, "rst_hold1");

    // Basic MAC.
    apply(0, 1, W431, 8'd2, 14'd1, 1, 14'd3,  8'd0, "mac0");
    apply(0, 1, W431, 8'd4, 14'd1, 1, 14'd11, 8'd0, "mac1");
    apply(0, 1, W431, 8'd1, 14'd1, 1, 14'd22, 8'd2, "mac2");
    apply(0, 1, W431, 8'd0, 14'd1, 1, 14'd20, 8'd4, "mac3");

    // Enable low: everything holds regardless of inputs.
    apply(0, 0, rf(), rx(), rp(), 1, 14'd20, 8'd4, "hold0");
    apply(0, 0, rf(), rx(), rp(), 1, 14'd20, 8'd4, "hold1");
    apply(0, 0, rf(), rx(), rp(), 1, 14'd20, 8'd4, "hold2");

    // Resume from taps x0=0, x1=1, x2=4.
    apply(0, 1, W431, 8'd3, 14'd1, 1, 14'd8,  8'd1, "resume0");
    apply(0, 1, W431, 8'd0, 14'd1, 1, 14'd10, 8'd0, "resume1");

    // Maximum operands.
    apply(0, 1, 12'hFFF, 8'd255, 14'd16383, 0, 0, 0, "ovf_fill0");
    apply(0, 1, 12'hFFF, 8'd255, 14'd16383, 0, 0, 0, "ovf_fill1");
    apply(0, 1, 12'hFFF, 8'd255, 14'd16383, 1, OVF_EXP, 8'd255, "ovf");

    // Largest in-range result: taps full, psum_in fills to 16383.
    apply(0, 1, 12'hFFF, 8'd255, 14'd4908, 1, 14'd16383, 8'd255,
          "edge_max");

    // Reset mid-stream discards taps.
    apply(0, 1, W431, 8'd7, 14'd0, 0, 0, 0, "mid_s0");
    apply(0, 1, W431, 8'd9, 14'd0, 0, 0, 0, "mid_s1");
    apply(1, 1, rf(), rx(), rp(), 1, 0, 0, "mid_rst");
    apply(0, 1, W111, 8'd5, 14'd0, 1, 14'd5, 8'd0, "mid_s5");
    apply(0, 1, W111, 8'd0, 14'd0, 1, 14'd5, 8'd0, "mid_n1");
    apply(0, 1, W111, 8'd0, 14'd0, 1, 14'd5, 8'd5, "mid_n2");

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard: got %0d entries left, expected 0",
               sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
